// File: rtl/cutoff_log_search.sv
// Inverse cutoff mapping: binary-searches the exponential cutoff ROM for the
// largest control index whose table entry does not exceed the requested frequency.
module cutoff_log_search #(
    parameter int lowest_tone    = 10,
    parameter int number_samples = 2048
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                START,
    input  logic [14:0]                         FREQ_IN,
    output logic                                BUSY,
    output logic                                DONE,
    output logic [$clog2(number_samples)-1:0]   CONTROL_VALUE,
    output logic [$clog2(number_samples)-1:4]   CUTOFF_CC_OUT,
    output logic [3:0]                          FINE_OUT,
    output logic                                UNDERFLOW
);

    localparam int IDX_W = $clog2(number_samples);
    localparam int BIT_W = $clog2(IDX_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_CMP,
        S_FIN
    } state_t;

    // Same curve as the forward cutoff table, evaluated at elaboration time.
    function automatic logic [14:0] tone_entry(input int i);
        real v;
        v = real'(lowest_tone) * (2.0 ** (real'(i) / 192.0));
        return 15'($rtoi(v));
    endfunction

    logic [14:0] rom_tbl [number_samples];
    logic [14:0] rom_q;

    genvar gi;
    generate
        for (gi = 0; gi < number_samples; gi++) begin : g_rom
            assign rom_tbl[gi] = tone_entry(gi);
        end
    endgenerate

    state_t             state_q, state_d;
    logic [14:0]        freq_q, freq_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [IDX_W-1:0]   ctrl_q, ctrl_d;
    logic               uflow_q, uflow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IDX_W-1:0]   trial;

    // OR-ing in the probe bit cannot carry, so the trial address never wraps.
    assign trial = idx_q | (IDX_W'(1) << bit_q);

    // Registered read keeps the ROM mappable onto block memory.
    always_ff @(posedge clk) begin
        if (state_q == S_READ) begin
            rom_q <= rom_tbl[trial];
        end
    end

    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        ctrl_d  = ctrl_q;
        uflow_d = uflow_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    freq_d  = FREQ_IN;
                    idx_d   = '0;
                    bit_d   = BIT_W'(IDX_W - 1);
                    busy_d  = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                if (rom_q <= freq_q) begin
                    idx_d = trial;
                end
                if (bit_q == '0) begin
                    // Results are captured on entry to FIN so they are valid with DONE.
                    ctrl_d  = idx_d;
                    uflow_d = (idx_d == '0) && (freq_q < 15'(lowest_tone));
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    bit_d   = bit_q - BIT_W'(1);
                    state_d = S_READ;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            freq_q  <= '0;
            idx_q   <= '0;
            bit_q   <= '0;
            ctrl_q  <= '0;
            uflow_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            ctrl_q  <= ctrl_d;
            uflow_q <= uflow_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign CONTROL_VALUE = ctrl_q;
    assign CUTOFF_CC_OUT = ctrl_q[IDX_W-1:4];
    assign FINE_OUT      = ctrl_q[3:0];
    assign UNDERFLOW     = uflow_q;

endmodule

// File: tb/tb_cutoff_log_search.sv
// Directed bench for cutoff_log_search: latency, handshake abuse, reset abort
// and a full-table sweep against a scan of the exponential table.
module tb_cutoff_log_search;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        START = 1'b0;
    logic [14:0] FREQ_IN = '0;
    logic        BUSY;
    logic        DONE;
    logic [10:0] CONTROL_VALUE;
    logic [6:0]  CUTOFF_CC_OUT;
    logic [3:0]  FINE_OUT;
    logic        UNDERFLOW;

    int n_checks = 0;
    int n_errors = 0;

    logic [14:0] tbl [2048];

    cutoff_log_search #(
        .lowest_tone   (10),
        .number_samples(2048)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .START        (START),
        .FREQ_IN      (FREQ_IN),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .CONTROL_VALUE(CONTROL_VALUE),
        .CUTOFF_CC_OUT(CUTOFF_CC_OUT),
        .FINE_OUT     (FINE_OUT),
        .UNDERFLOW    (UNDERFLOW)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts a conversion and follows it for up to 30 cycles. Cycle n is the
    // n-th cycle after the edge that accepted START; mid-run events are applied
    // during cycle n so the following edge samples them.
    task automatic run_conv(input logic [14:0] f, input int chg_at, input logic [14:0] f_alt,
                            input int pulse_at, input int rst_at,
                            output int done_at, output int busy_cnt, output int cv_mid,
                            output int busy_after, output int cv_after);
        done_at = 0; busy_cnt = 0; cv_mid = -1; busy_after = -1; cv_after = -1;
        START = 1'b1;
        FREQ_IN = f;
        @(posedge clk); #1;
        START = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (DONE && done_at == 0) done_at = n;
            if (BUSY) busy_cnt++;
            if (n == 10) cv_mid = int'(CONTROL_VALUE);
            if (n == rst_at + 1) begin
                busy_after = int'(BUSY);
                cv_after   = int'(CONTROL_VALUE);
            end
            if (done_at != 0) break;
            START = (n == pulse_at);
            if (n == chg_at) FREQ_IN = f_alt;
            rst = (n == rst_at);
            @(posedge clk); #1;
        end
        START = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic directed(input string tag, input logic [14:0] f, input int exp_cv, input int exp_uf);
        int d, b, m, ba, ca;
        run_conv(f, 0, '0, 0, 0, d, b, m, ba, ca);
        $display("conv %s f=%0d cv=%0d cc=%0d fine=%0d uf=%0d done_at=%0d busy=%0d",
                 tag, f, CONTROL_VALUE, CUTOFF_CC_OUT, FINE_OUT, UNDERFLOW, d, b);
        check_eq({tag, "_done_at"}, d, 23);
        check_eq({tag, "_cv"}, CONTROL_VALUE, exp_cv);
        check_eq({tag, "_uf"}, UNDERFLOW, exp_uf);
    endtask

    initial begin
        int d, b, m, ba, ca, dones, first, last, r;

        for (int i = 0; i < 2048; i++) begin
            tbl[i] = 15'($rtoi(10.0 * (2.0 ** (real'(i) / 192.0))));
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", BUSY, 0);
        check_eq("rst_done", DONE, 0);
        check_eq("rst_cv", CONTROL_VALUE, 0);
        check_eq("rst_uf", UNDERFLOW, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // First conversion: timing and field split
        run_conv(15'd403, 0, '0, 0, 0, d, b, m, ba, ca);
        $display("conv f=403 cv=%0d cc=%0d fine=%0d uf=%0d done_at=%0d busy=%0d",
                 CONTROL_VALUE, CUTOFF_CC_OUT, FINE_OUT, UNDERFLOW, d, b);
        check_eq("f403_done_at", d, 23);
        check_eq("f403_busy_cycles", b, 22);
        check_eq("f403_cv", CONTROL_VALUE, 1024);
        check_eq("f403_cc", CUTOFF_CC_OUT, 64);
        check_eq("f403_fine", FINE_OUT, 0);
        check_eq("f403_uf", UNDERFLOW, 0);
        check_eq("f403_hold_cv", CONTROL_VALUE, 1024);
        check_eq("f403_done_pulse", DONE, 0);

        directed("f10", 15'd10, 26, 0);
        directed("f20", 15'd20, 205, 0);
        directed("f9", 15'd9, 0, 1);
        directed("fmax", 15'd32767, 2047, 0);
        check_eq("fmax_cc", CUTOFF_CC_OUT, 127);
        check_eq("fmax_fine", FINE_OUT, 15);

        // START held high: one conversion per 24 cycles
        FREQ_IN = 15'd403;
        START = 1'b1;
        dones = 0; first = 0; last = 0;
        @(posedge clk); #1;
        for (int n = 1; n <= 72; n++) begin
            if (DONE) begin
                dones++;
                if (first == 0) first = n;
                else check_eq("held_gap", n - last, 24);
                last = n;
            end
            if (n == 72) START = 1'b0;
            @(posedge clk); #1;
        end
        $display("held start dones=%0d first=%0d cv=%0d", dones, first, CONTROL_VALUE);
        check_eq("held_dones", dones, 3);
        check_eq("held_first", first, 23);
        check_eq("held_cv", CONTROL_VALUE, 1024);
        check_eq("held_idle_busy", BUSY, 0);

        // Stray START at +5 and FREQ_IN change at +3 during a conversion
        run_conv(15'd10, 3, 15'd32767, 5, 0, d, b, m, ba, ca);
        $display("abuse f=10 cv=%0d done_at=%0d cv_mid=%0d", CONTROL_VALUE, d, m);
        check_eq("abuse_done_at", d, 23);
        check_eq("abuse_cv", CONTROL_VALUE, 26);
        check_eq("abuse_cv_mid", m, 1024);
        dones = 0;
        for (int n = 0; n < 30; n++) begin
            if (DONE || BUSY) dones++;
            @(posedge clk); #1;
        end
        check_eq("abuse_no_extra", dones, 0);

        // Reset at +10 aborts the conversion without a DONE
        run_conv(15'd403, 0, '0, 0, 10, d, b, m, ba, ca);
        $display("abort f=403 done_at=%0d busy_after=%0d cv_after=%0d", d, ba, ca);
        check_eq("abort_busy", ba, 0);
        check_eq("abort_cv", ca, 0);
        check_eq("abort_no_done", d, 0);
        check_eq("abort_busy_cycles", b, 10);
        directed("after_abort_f20", 15'd20, 205, 0);

        // Reset and START together: reset wins
        rst = 1'b1;
        START = 1'b1;
        FREQ_IN = 15'd403;
        @(posedge clk); #1;
        rst = 1'b0;
        START = 1'b0;
        @(posedge clk); #1;
        $display("rst+start busy=%0d cv=%0d", BUSY, CONTROL_VALUE);
        check_eq("rst_start_busy", BUSY, 0);
        check_eq("rst_start_cv", CONTROL_VALUE, 0);

        // Full sweep: the answer is the last index holding the same entry
        for (int i = 0; i < 2048; i++) begin
            r = i;
            while (r < 2047 && tbl[r + 1] == tbl[i]) r++;
            run_conv(tbl[i], 0, '0, 0, 0, d, b, m, ba, ca);
            $display("sweep i=%0d f=%0d cv=%0d exp=%0d", i, tbl[i], CONTROL_VALUE, r);
            check_eq("sweep_cv", CONTROL_VALUE, r);
            if (d != 23) check_eq("sweep_done_at", d, 23);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
